// File: rtl/det_scheduler_if.sv
// Requester-side bus of det_scheduler: per-requester request handshake plus
// the shared response handshake carrying the served ID and the match count.
interface det_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1),
    parameter int ID_W   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*WORD_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [CNT_W-1:0]        rsp_count;
    logic                    rsp_ready;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_count
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_count
    );
endinterface

// File: rtl/det_scheduler.sv
// Round-robin scheduler sharing one serial sequence detector between requesters:
// clears it, shifts the granted word in MSB-first and counts high detector samples.
module det_scheduler #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1),
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic           clock,
    input  logic           reset,
    det_scheduler_if.slave bus,
    output logic           det_reset,
    output logic           det_in,
    input  logic           det_out,
    output logic           busy
);

    localparam int K_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        FLUSH,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              det_reset_q, det_reset_d;
    logic              det_in_q, det_in_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     cand_sum;
    logic [ID_W-1:0]   cand;
    logic [WORD_W-1:0] grant_word;
    logic [N_REQ-1:0]  ready;

    // Search for the first valid requester starting at the pointer, wrapping at N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_sum = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (cand_sum >= (ID_W + 1)'(N_REQ)) begin
                cand_sum = cand_sum - (ID_W + 1)'(N_REQ);
            end
            cand = cand_sum[ID_W-1:0];
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                grant_word = bus.req_data[i*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state_q == IDLE && grant_found) begin
            ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        det_reset_d = 1'b0;
        det_in_d    = 1'b0;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d     = CLR;
                    word_d      = grant_word;
                    id_d        = grant_idx;
                    cnt_d       = '0;
                    ptr_d       = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    det_reset_d = 1'b1;
                end
            end
            CLR: begin
                state_d  = SHIFT;
                k_d      = '0;
                det_in_d = word_q[WORD_W-1];
                word_d   = word_q << 1;
            end
            SHIFT: begin
                // The first SHIFT cycle still shows the cleared detector, so it is not sampled.
                if (k_q != '0 && det_out && cnt_q != CNT_W'(WORD_W)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (k_q == K_W'(WORD_W - 1)) begin
                    state_d = FLUSH;
                end else begin
                    k_d      = k_q + 1'b1;
                    det_in_d = word_q[WORD_W-1];
                    word_d   = word_q << 1;
                end
            end
            FLUSH: begin
                if (det_out && cnt_q != CNT_W'(WORD_W)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d     = DONE;
                rsp_valid_d = 1'b1;
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            word_q      <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            det_reset_q <= 1'b0;
            det_in_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            det_reset_q <= det_reset_d;
            det_in_q    <= det_in_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_count = cnt_q;
    assign det_reset     = det_reset_q;
    assign det_in        = det_in_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_det_scheduler.sv
// Self-checking bench for det_scheduler with a one-cycle-delay stub detector,
// so every response count must equal the popcount of the served word.
module tb_det_scheduler;

    localparam int N_REQ  = 4;
    localparam int WORD_W = 8;
    localparam int CNT_W  = $clog2(WORD_W + 1);
    localparam int ID_W   = $clog2(N_REQ);

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic det_reset, det_in, det_out, busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int model_ptr = 0;

    always #5 clock = ~clock;

    det_scheduler_if #(.N_REQ(N_REQ), .WORD_W(WORD_W)) bus ();

    det_scheduler #(.N_REQ(N_REQ), .WORD_W(WORD_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .det_reset (det_reset),
        .det_in    (det_in),
        .det_out   (det_out),
        .busy      (busy)
    );

    // Stub detector: echoes det_in one cycle later, cleared by det_reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) det_out <= 1'b0;
        else if (det_reset) det_out <= 1'b0;
        else det_out <= det_in;
    end

    function automatic int rr_pick(input logic [N_REQ-1:0] mask, input int ptr);
        for (int i = 0; i < N_REQ; i++) begin
            if (mask[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [WORD_W-1:0] slot(input logic [N_REQ*WORD_W-1:0] d, input int i);
        return d[i*WORD_W +: WORD_W];
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input int i);
        logic [N_REQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic send_one(input int id, input logic [WORD_W-1:0] w, output bit ok);
        ok = 1'b0;
        bus.req_data[id*WORD_W +: WORD_W] = w;
        bus.req_valid[id] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (bus.req_ready[id]) ok = 1'b1;
            next_cycle();
            if (ok) break;
        end
        if (ok) model_ptr = (id + 1) % N_REQ;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic drain(output bit ok, output logic [ID_W-1:0] id, output logic [CNT_W-1:0] cnt);
        ok  = 1'b0;
        id  = '0;
        cnt = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus.rsp_valid) begin
                id  = bus.rsp_id;
                cnt = bus.rsp_count;
                bus.rsp_ready = 1'b1;
                ok = 1'b1;
            end
            next_cycle();
            if (ok) begin
                bus.rsp_ready = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total_cnt++; if (bus.req_ready !== '0) $display("[TB] FAIL reset_req_ready: got %0h, expected 0", bus.req_ready); else pass_cnt++;
        total_cnt++; if (det_reset !== 1'b0) $display("[TB] FAIL reset_det_reset: got %0b, expected 0", det_reset); else pass_cnt++;
        total_cnt++; if (det_in !== 1'b0) $display("[TB] FAIL reset_det_in: got %0b, expected 0", det_in); else pass_cnt++;
        total_cnt++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %0b, expected 0", bus.rsp_valid); else pass_cnt++;
        total_cnt++; if (bus.rsp_id !== '0) $display("[TB] FAIL reset_rsp_id: got %0d, expected 0", bus.rsp_id); else pass_cnt++;
        total_cnt++; if (bus.rsp_count !== '0) $display("[TB] FAIL reset_rsp_count: got %0d, expected 0", bus.rsp_count); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); else pass_cnt++;
        reset = 1'b1;
        model_ptr = 0;
        next_cycle();
    endtask

    task automatic test_fairness();
        logic [N_REQ*WORD_W-1:0] data;
        int exp_id[$];
        int exp_cnt[$];
        int n = 0;
        int last = 0;
        int g;
        for (int i = 0; i < N_REQ; i++) data[i*WORD_W +: WORD_W] = WORD_W'($urandom);
        bus.req_data  = data;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && (n < 5 || exp_id.size() > 0); cyc++) begin
            @(negedge clock);
            if (bus.rsp_valid && exp_id.size() > 0) begin
                total_cnt++; if (bus.rsp_id !== ID_W'(exp_id[0])) $display("[TB] FAIL fair_rsp_id: got %0d, expected %0d", bus.rsp_id, exp_id[0]); else pass_cnt++;
                total_cnt++; if (bus.rsp_count !== CNT_W'(exp_cnt[0])) $display("[TB] FAIL fair_rsp_count: got %0d, expected %0d", bus.rsp_count, exp_cnt[0]); else pass_cnt++;
                void'(exp_id.pop_front());
                void'(exp_cnt.pop_front());
            end
            if (bus.req_ready !== '0) begin
                g = rr_pick(bus.req_valid, model_ptr);
                total_cnt++; if (bus.req_ready !== onehot(g)) $display("[TB] FAIL fair_grant: got %0h, expected %0h", bus.req_ready, onehot(g)); else pass_cnt++;
                if (n > 0) begin
                    total_cnt++; if (cyc - last !== 12) $display("[TB] FAIL fair_spacing: got %0d, expected 12", cyc - last); else pass_cnt++;
                end
                last = cyc;
                n++;
                exp_id.push_back(g);
                exp_cnt.push_back($countones(slot(data, g)));
                model_ptr = (g + 1) % N_REQ;
            end
            next_cycle();
            if (n == 5) bus.req_valid = '0;
        end
        total_cnt++; if (n !== 5 || exp_id.size() !== 0) $display("[TB] FAIL fair_timeout: got %0d grants, expected 5", n); else pass_cnt++;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_single();
        logic [WORD_W-1:0] w;
        w = 8'b0110_1011;
        bus.req_data  = '0;
        bus.req_data[WORD_W-1:0] = w;
        bus.req_valid = 4'b0001;
        @(negedge clock);
        total_cnt++; if (bus.req_ready !== 4'b0001) $display("[TB] FAIL single_ready_c0: got %0h, expected 1", bus.req_ready); else pass_cnt++;
        next_cycle();
        bus.req_valid = '0;
        model_ptr = 1;
        @(negedge clock);
        total_cnt++; if (det_reset !== 1'b1) $display("[TB] FAIL single_det_reset_c1: got %0b, expected 1", det_reset); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL single_busy_c1: got %0b, expected 1", busy); else pass_cnt++;
        for (int k = 0; k < WORD_W; k++) begin
            next_cycle();
            @(negedge clock);
            total_cnt++; if (det_in !== w[WORD_W-1-k]) $display("[TB] FAIL single_det_in_c%0d: got %0b, expected %0b", k + 2, det_in, w[WORD_W-1-k]); else pass_cnt++;
        end
        next_cycle();
        @(negedge clock);
        total_cnt++; if (det_in !== 1'b0 || bus.rsp_valid !== 1'b0) $display("[TB] FAIL single_flush: got det_in=%0b rsp_valid=%0b, expected 0/0", det_in, bus.rsp_valid); else pass_cnt++;
        next_cycle();
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        total_cnt++; if (bus.rsp_valid !== 1'b1) $display("[TB] FAIL single_rsp_valid_c11: got %0b, expected 1", bus.rsp_valid); else pass_cnt++;
        total_cnt++; if (bus.rsp_id !== 2'd0) $display("[TB] FAIL single_rsp_id: got %0d, expected 0", bus.rsp_id); else pass_cnt++;
        total_cnt++; if (bus.rsp_count !== 4'd5) $display("[TB] FAIL single_rsp_count: got %0d, expected 5", bus.rsp_count); else pass_cnt++;
        next_cycle();
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        total_cnt++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL single_after_hs: got rsp_valid=%0b busy=%0b, expected 0/0", bus.rsp_valid, busy); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [WORD_W-1:0] w;
        logic [N_REQ*WORD_W-1:0] data;
        bit ok;
        bit seen;
        int g;
        logic [ID_W-1:0] rid;
        logic [CNT_W-1:0] rcnt;
        w = WORD_W'($urandom);
        send_one(2, w, ok);
        total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL bp_accept_timeout: got %0b, expected 1", ok); else pass_cnt++;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
            next_cycle();
        end
        total_cnt++; if (seen !== 1'b1) $display("[TB] FAIL bp_rsp_timeout: got %0b, expected 1", seen); else pass_cnt++;
        for (int i = 0; i < N_REQ; i++) data[i*WORD_W +: WORD_W] = WORD_W'($urandom);
        bus.req_data  = data;
        bus.req_valid = '1;
        for (int b = 0; b < 5; b++) begin
            if (b > 0) @(negedge clock);
            total_cnt++; if (bus.rsp_valid !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL bp_hold_valid_busy: got %0b/%0b, expected 1/1", bus.rsp_valid, busy); else pass_cnt++;
            total_cnt++; if (bus.rsp_id !== 2'd2) $display("[TB] FAIL bp_hold_id: got %0d, expected 2", bus.rsp_id); else pass_cnt++;
            total_cnt++; if (bus.rsp_count !== CNT_W'($countones(w))) $display("[TB] FAIL bp_hold_count: got %0d, expected %0d", bus.rsp_count, $countones(w)); else pass_cnt++;
            total_cnt++; if (bus.req_ready !== '0) $display("[TB] FAIL bp_hold_ready: got %0h, expected 0", bus.req_ready); else pass_cnt++;
            next_cycle();
        end
        bus.rsp_ready = 1'b1;
        next_cycle();
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        g = rr_pick(bus.req_valid, model_ptr);
        total_cnt++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL bp_idle_cycle: got rsp_valid=%0b busy=%0b, expected 0/0", bus.rsp_valid, busy); else pass_cnt++;
        total_cnt++; if (bus.req_ready !== onehot(g)) $display("[TB] FAIL bp_next_grant: got %0h, expected %0h", bus.req_ready, onehot(g)); else pass_cnt++;
        next_cycle();
        bus.req_valid = '0;
        model_ptr = (g + 1) % N_REQ;
        @(negedge clock);
        total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL bp_next_busy: got %0b, expected 1", busy); else pass_cnt++;
        drain(ok, rid, rcnt);
        total_cnt++; if (!ok || rid !== ID_W'(g) || rcnt !== CNT_W'($countones(slot(data, g)))) $display("[TB] FAIL bp_next_rsp: got ok=%0b id=%0d cnt=%0d, expected id=%0d cnt=%0d", ok, rid, rcnt, g, $countones(slot(data, g))); else pass_cnt++;
    endtask

    task automatic test_width_boundary();
        bit ok;
        logic [ID_W-1:0] rid;
        logic [CNT_W-1:0] rcnt;
        send_one(1, 8'hFF, ok);
        drain(ok, rid, rcnt);
        total_cnt++; if (!ok || rid !== 2'd1 || rcnt !== 4'd8) $display("[TB] FAIL width_ff: got ok=%0b id=%0d cnt=%0d, expected id=1 cnt=8", ok, rid, rcnt); else pass_cnt++;
        send_one(3, 8'h00, ok);
        drain(ok, rid, rcnt);
        total_cnt++; if (!ok || rid !== 2'd3 || rcnt !== 4'd0) $display("[TB] FAIL width_00: got ok=%0b id=%0d cnt=%0d, expected id=3 cnt=0", ok, rid, rcnt); else pass_cnt++;
    endtask

    task automatic test_pointer_skip();
        bit ok;
        int g;
        logic [WORD_W-1:0] w;
        logic [ID_W-1:0] rid;
        logic [CNT_W-1:0] rcnt;
        send_one(0, WORD_W'($urandom), ok);
        drain(ok, rid, rcnt);
        total_cnt++; if (model_ptr !== 1 || !ok) $display("[TB] FAIL skip_setup: got ptr=%0d ok=%0b, expected ptr=1", model_ptr, ok); else pass_cnt++;
        w = WORD_W'($urandom);
        bus.req_data[2*WORD_W +: WORD_W] = w;
        bus.req_valid = 4'b0100;
        @(negedge clock);
        g = rr_pick(bus.req_valid, model_ptr);
        total_cnt++; if (bus.req_ready !== onehot(g)) $display("[TB] FAIL skip_grant_2: got %0h, expected %0h", bus.req_ready, onehot(g)); else pass_cnt++;
        next_cycle();
        bus.req_valid = '0;
        model_ptr = (g + 1) % N_REQ;
        drain(ok, rid, rcnt);
        total_cnt++; if (!ok || rid !== 2'd2 || rcnt !== CNT_W'($countones(w))) $display("[TB] FAIL skip_rsp_2: got id=%0d cnt=%0d, expected id=2 cnt=%0d", rid, rcnt, $countones(w)); else pass_cnt++;
        bus.req_valid = 4'b1001;
        @(negedge clock);
        g = rr_pick(bus.req_valid, model_ptr);
        total_cnt++; if (bus.req_ready !== 4'b1000 || g !== 3) $display("[TB] FAIL skip_grant_3: got %0h, expected 8", bus.req_ready); else pass_cnt++;
        next_cycle();
        bus.req_valid = '0;
        model_ptr = (g + 1) % N_REQ;
        drain(ok, rid, rcnt);
        total_cnt++; if (!ok || rid !== 2'd3) $display("[TB] FAIL skip_rsp_3: got id=%0d, expected 3", rid); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] mask;
        logic [N_REQ*WORD_W-1:0] data;
        int g;
        int hold;
        bit seen;
        for (int it = 0; it < 20; it++) begin
            mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++) data[i*WORD_W +: WORD_W] = WORD_W'($urandom);
            bus.req_data  = data;
            bus.req_valid = mask;
            @(negedge clock);
            g = rr_pick(mask, model_ptr);
            total_cnt++; if (bus.req_ready !== onehot(g)) $display("[TB] FAIL rand_grant_%0d: got %0h, expected %0h", it, bus.req_ready, onehot(g)); else pass_cnt++;
            next_cycle();
            bus.req_valid = '0;
            model_ptr = (g + 1) % N_REQ;
            seen = 1'b0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clock);
                if (bus.rsp_valid) begin
                    seen = 1'b1;
                    break;
                end
                next_cycle();
            end
            total_cnt++; if (!seen || bus.rsp_id !== ID_W'(g) || bus.rsp_count !== CNT_W'($countones(slot(data, g)))) $display("[TB] FAIL rand_rsp_%0d: got seen=%0b id=%0d cnt=%0d, expected id=%0d cnt=%0d", it, seen, bus.rsp_id, bus.rsp_count, g, $countones(slot(data, g))); else pass_cnt++;
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                next_cycle();
                @(negedge clock);
                total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(g)) $display("[TB] FAIL rand_hold_%0d: got valid=%0b id=%0d, expected 1/%0d", it, bus.rsp_valid, bus.rsp_id, g); else pass_cnt++;
            end
            bus.rsp_ready = 1'b1;
            next_cycle();
            bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit seen;
        logic [N_REQ*WORD_W-1:0] data;
        logic [ID_W-1:0] rid;
        logic [CNT_W-1:0] rcnt;
        send_one($urandom_range(0, N_REQ - 1), 8'hFF, ok);
        repeat (6) next_cycle();
        #2;
        total_cnt++; if (busy !== 1'b1 || det_in !== 1'b1) $display("[TB] FAIL mid_pre_reset: got busy=%0b det_in=%0b, expected 1/1", busy, det_in); else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0 || det_in !== 1'b0 || det_reset !== 1'b0) $display("[TB] FAIL mid_async_ctrl: got busy=%0b det_in=%0b det_reset=%0b, expected 0", busy, det_in, det_reset); else pass_cnt++;
        total_cnt++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_count !== '0 || bus.req_ready !== '0) $display("[TB] FAIL mid_async_rsp: got valid=%0b id=%0d cnt=%0d ready=%0h, expected 0", bus.rsp_valid, bus.rsp_id, bus.rsp_count, bus.req_ready); else pass_cnt++;
        @(negedge clock);
        reset = 1'b1;
        model_ptr = 0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            if (bus.rsp_valid || busy) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("[TB] FAIL mid_no_rsp: got activity=%0b, expected 0", seen); else pass_cnt++;
        for (int i = 0; i < N_REQ; i++) data[i*WORD_W +: WORD_W] = WORD_W'($urandom);
        bus.req_data  = data;
        bus.req_valid = '1;
        @(negedge clock);
        total_cnt++; if (bus.req_ready !== onehot(rr_pick('1, model_ptr))) $display("[TB] FAIL mid_first_grant: got %0h, expected 1", bus.req_ready); else pass_cnt++;
        next_cycle();
        bus.req_valid = '0;
        model_ptr = 1;
        drain(ok, rid, rcnt);
        total_cnt++; if (!ok || rid !== 2'd0 || rcnt !== CNT_W'($countones(slot(data, 0)))) $display("[TB] FAIL mid_rsp: got id=%0d cnt=%0d, expected id=0 cnt=%0d", rid, rcnt, $countones(slot(data, 0))); else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_width_boundary();
        test_pointer_skip();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
